// File: rtl/sp_dev_arbiter_if.sv
// Request/response port of one host that shares a single-port device through sp_dev_arbiter.
// The host drives the command side (master); the arbiter answers with grant and response (slave).
interface sp_dev_arbiter_if #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
);
    logic                    req;
    logic                    we;
    logic [DataWidth/8-1:0]  be;
    logic [AddressWidth-1:0] addr;
    logic [DataWidth-1:0]    wdata;
    logic                    gnt;
    logic                    rvalid;
    logic [DataWidth-1:0]    rdata;
    logic                    err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/sp_dev_arbiter.sv
// Shares one fixed-latency single-port device between two hosts A and B: same-cycle grant,
// round-robin or fixed-priority on contention, responses routed back by an owner tracker.
module sp_dev_arbiter #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned Latency      = 1,
    parameter bit          FixedPrio    = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    sp_dev_arbiter_if.slave         a_bus,
    sp_dev_arbiter_if.slave         b_bus,

    output logic                    dev_req_o,
    output logic                    dev_we_o,
    output logic [DataWidth/8-1:0]  dev_be_o,
    output logic [AddressWidth-1:0] dev_addr_o,
    output logic [DataWidth-1:0]    dev_wdata_o,
    input  logic                    dev_rvalid_i,
    input  logic [DataWidth-1:0]    dev_rdata_i,
    input  logic                    dev_err_i,

    output logic                    protocol_err_o
);

    // prio_q names the host that wins the next contended cycle: 0 = A, 1 = B.
    logic               prio_q;
    logic               gnt_a;
    logic               gnt_b;
    logic [Latency-1:0] vld_p;
    logic [Latency-1:0] own_p;
    logic               oldest_vld;
    logic               oldest_own;
    logic               rsp_hit;
    logic               perr_q;

    // Request stage: combinational grant and command mux
    always_comb begin
        gnt_a = a_bus.req & (~b_bus.req | FixedPrio | ~prio_q);
        gnt_b = b_bus.req & ~gnt_a;
    end

    assign a_bus.gnt   = gnt_a;
    assign b_bus.gnt   = gnt_b;

    assign dev_req_o   = a_bus.req | b_bus.req;
    assign dev_we_o    = gnt_b ? b_bus.we    : a_bus.we;
    assign dev_be_o    = gnt_b ? b_bus.be    : a_bus.be;
    assign dev_addr_o  = gnt_b ? b_bus.addr  : a_bus.addr;
    assign dev_wdata_o = gnt_b ? b_bus.wdata : a_bus.wdata;

    // Tracker stage: one {valid, owner} slot per cycle of device latency
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
            vld_p  <= '0;
            own_p  <= '0;
            perr_q <= 1'b0;
        end else begin
            if (gnt_a) begin
                prio_q <= 1'b1;
            end else if (gnt_b) begin
                prio_q <= 1'b0;
            end
            vld_p[0] <= dev_req_o;
            own_p[0] <= gnt_b;
            for (int i = 1; i < int'(Latency); i++) begin
                vld_p[i] <= vld_p[i-1];
                own_p[i] <= own_p[i-1];
            end
            // Any disagreement between device and tracker is a latency violation.
            if (dev_rvalid_i != oldest_vld) begin
                perr_q <= 1'b1;
            end
        end
    end

    // Response stage: route the device response to the owner of the oldest slot
    assign oldest_vld = vld_p[Latency-1];
    assign oldest_own = own_p[Latency-1];
    assign rsp_hit    = dev_rvalid_i & oldest_vld;

    assign a_bus.rvalid = rsp_hit & ~oldest_own;
    assign b_bus.rvalid = rsp_hit &  oldest_own;
    assign a_bus.err    = rsp_hit & ~oldest_own & dev_err_i;
    assign b_bus.err    = rsp_hit &  oldest_own & dev_err_i;
    assign a_bus.rdata  = dev_rdata_i;
    assign b_bus.rdata  = dev_rdata_i;

    assign protocol_err_o = perr_q;

endmodule

// File: tb/tb_sp_dev_arbiter.sv
// Bench for sp_dev_arbiter: three instances (Latency 1/2/3, the last with fixed priority)
// driven by directed steps and random traffic, checked against a queue-based reference model.
module tb_sp_dev_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          a_req[N], b_req[N], a_we[N], b_we[N];
    logic [3:0]    a_be[N], b_be[N];
    logic [AW-1:0] a_addr[N], b_addr[N];
    logic [DW-1:0] a_wdata[N], b_wdata[N];
    logic          a_gnt[N], b_gnt[N], a_rvalid[N], b_rvalid[N], a_err[N], b_err[N];
    logic [DW-1:0] a_rdata[N], b_rdata[N];
    logic          dev_req[N], dev_we[N];
    logic [3:0]    dev_be[N];
    logic [AW-1:0] dev_addr[N];
    logic [DW-1:0] dev_wdata[N];
    logic          dev_rvalid[N], dev_err[N];
    logic [DW-1:0] dev_rdata[N];
    logic          perr[N];

    for (genvar k = 0; k < N; k++) begin : g_dut
        sp_dev_arbiter_if #(.DataWidth(DW), .AddressWidth(AW)) a_bus ();
        sp_dev_arbiter_if #(.DataWidth(DW), .AddressWidth(AW)) b_bus ();

        assign a_bus.req   = a_req[k];
        assign a_bus.we    = a_we[k];
        assign a_bus.be    = a_be[k];
        assign a_bus.addr  = a_addr[k];
        assign a_bus.wdata = a_wdata[k];
        assign a_gnt[k]    = a_bus.gnt;
        assign a_rvalid[k] = a_bus.rvalid;
        assign a_rdata[k]  = a_bus.rdata;
        assign a_err[k]    = a_bus.err;

        assign b_bus.req   = b_req[k];
        assign b_bus.we    = b_we[k];
        assign b_bus.be    = b_be[k];
        assign b_bus.addr  = b_addr[k];
        assign b_bus.wdata = b_wdata[k];
        assign b_gnt[k]    = b_bus.gnt;
        assign b_rvalid[k] = b_bus.rvalid;
        assign b_rdata[k]  = b_bus.rdata;
        assign b_err[k]    = b_bus.err;

        sp_dev_arbiter #(
            .DataWidth(DW), .AddressWidth(AW), .Latency(k + 1), .FixedPrio(k == 2)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .a_bus(a_bus), .b_bus(b_bus),
            .dev_req_o(dev_req[k]), .dev_we_o(dev_we[k]), .dev_be_o(dev_be[k]),
            .dev_addr_o(dev_addr[k]), .dev_wdata_o(dev_wdata[k]),
            .dev_rvalid_i(dev_rvalid[k]), .dev_rdata_i(dev_rdata[k]), .dev_err_i(dev_err[k]),
            .protocol_err_o(perr[k])
        );
    end

    // Reference model: outstanding transactions as {instance, due cycle, owner}.
    typedef struct { int k; int due; bit own; } txn_t;
    txn_t pend[$];
    bit   prio_m[N], perr_m[N], ga_last[N], gb_last[N];
    bit   spur[N], drop[N], force_data[N];
    logic [DW-1:0] data_val[N];
    bit   err_on_b;
    int   cyc;
    int   checks = 0;
    int   errors = 0;

    function automatic int lat_of(int k);
        return k + 1;
    endfunction

    function automatic bit fixed_of(int k);
        return k == 2;
    endfunction

    function automatic int find_head(int k);
        for (int i = 0; i < pend.size(); i++) if (pend[i].k == k) return i;
        return -1;
    endfunction

    function automatic string tag(string s, int k);
        return $sformatf("%s[%0d]", s, k);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Called just after a rising edge: drives device responses, checks at the falling edge,
    // then advances the model by one cycle.
    task automatic eval();
        int hi;
        bit has, own, eg_a, eg_b, hit;
        for (int k = 0; k < N; k++) begin
            hi  = find_head(k);
            has = (hi >= 0) && (pend[hi].due == cyc);
            own = has ? pend[hi].own : 1'b0;
            dev_rvalid[k] = has ? !drop[k] : spur[k];
            dev_rdata[k]  = force_data[k] ? data_val[k] : $urandom();
            dev_err[k]    = err_on_b ? (has && own) : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            hi   = find_head(k);
            has  = (hi >= 0) && (pend[hi].due == cyc);
            own  = has ? pend[hi].own : 1'b0;
            eg_a = a_req[k] && (!b_req[k] || fixed_of(k) || !prio_m[k]);
            eg_b = b_req[k] && !eg_a;
            hit  = dev_rvalid[k] && has;
            chk(tag("a_gnt", k), a_gnt[k], eg_a);
            chk(tag("b_gnt", k), b_gnt[k], eg_b);
            chk(tag("dev_req", k), dev_req[k], a_req[k] || b_req[k]);
            chk(tag("dev_we", k), dev_we[k], eg_b ? b_we[k] : a_we[k]);
            chk(tag("dev_be", k), dev_be[k], eg_b ? b_be[k] : a_be[k]);
            chk(tag("dev_addr", k), dev_addr[k], eg_b ? b_addr[k] : a_addr[k]);
            chk(tag("dev_wdata", k), dev_wdata[k], eg_b ? b_wdata[k] : a_wdata[k]);
            chk(tag("a_rvalid", k), a_rvalid[k], hit && !own);
            chk(tag("b_rvalid", k), b_rvalid[k], hit && own);
            chk(tag("a_err", k), a_err[k], hit && !own && dev_err[k]);
            chk(tag("b_err", k), b_err[k], hit && own && dev_err[k]);
            chk(tag("a_rdata", k), a_rdata[k], dev_rdata[k]);
            chk(tag("b_rdata", k), b_rdata[k], dev_rdata[k]);
            chk(tag("protocol_err", k), perr[k], perr_m[k]);
            if (dev_rvalid[k] != has) perr_m[k] = 1'b1;
            if (has) pend.delete(hi);
            if (eg_a || eg_b) pend.push_back('{k, cyc + lat_of(k), eg_b});
            if (eg_a) prio_m[k] = 1'b1;
            else if (eg_b) prio_m[k] = 1'b0;
            ga_last[k] = eg_a;
            gb_last[k] = eg_b;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N; k++) begin
            spur[k] = 1'b0;
            drop[k] = 1'b0;
            force_data[k] = 1'b0;
        end
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) begin
            a_req[k] = 1'b0;
            b_req[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        idle_all();
        for (int k = 0; k < N; k++) dev_rvalid[k] = 1'b1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            chk(tag("rst_a_rvalid", k), a_rvalid[k], 1'b0);
            chk(tag("rst_b_rvalid", k), b_rvalid[k], 1'b0);
            chk(tag("rst_a_err", k), a_err[k], 1'b0);
            chk(tag("rst_b_err", k), b_err[k], 1'b0);
            chk(tag("rst_perr", k), perr[k], 1'b0);
            chk(tag("rst_a_gnt", k), a_gnt[k], 1'b0);
            prio_m[k]  = 1'b0;
            perr_m[k]  = 1'b0;
            ga_last[k] = 1'b0;
            gb_last[k] = 1'b0;
        end
        pend.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) dev_rvalid[k] = 1'b0;
        rst_n = 1'b1;
        cyc += 2;
    endtask

    task automatic drive_random();
        for (int k = 0; k < N; k++) begin
            if (!(a_req[k] && !ga_last[k])) begin
                a_req[k]   = ($urandom_range(0, 3) != 0);
                a_we[k]    = 1'($urandom_range(0, 1));
                a_be[k]    = 4'($urandom());
                a_addr[k]  = $urandom();
                a_wdata[k] = $urandom();
            end
            if (!(b_req[k] && !gb_last[k])) begin
                b_req[k]   = ($urandom_range(0, 3) != 0);
                b_we[k]    = 1'($urandom_range(0, 1));
                b_be[k]    = 4'($urandom());
                b_addr[k]  = $urandom();
                b_wdata[k] = $urandom();
            end
        end
    endtask

    initial begin
        cyc = 0;
        err_on_b = 1'b1;
        for (int k = 0; k < N; k++) begin
            a_req[k] = 0; b_req[k] = 0; a_we[k] = 0; b_we[k] = 0;
            a_be[k] = 4'hF; b_be[k] = 4'hF; a_addr[k] = '0; b_addr[k] = '0;
            a_wdata[k] = '0; b_wdata[k] = '0;
            dev_rvalid[k] = 0; dev_err[k] = 0; dev_rdata[k] = '0;
            spur[k] = 0; drop[k] = 0; force_data[k] = 0; data_val[k] = '0;
        end
        #1;
        do_reset();

        // Round-robin contention on the Latency=1 instance, starting from prio=A.
        a_addr[0] = 32'h0000_0100;
        b_addr[0] = 32'h0000_0200;
        for (int i = 0; i < 6; i++) begin
            a_req[0] = 1'b1;
            b_req[0] = 1'b1;
            eval();
            chk("rr_a_gnt", a_gnt[0], (i % 2) == 0);
            chk("rr_b_gnt", b_gnt[0], (i % 2) == 1);
            tick();
        end
        idle_all();
        step();
        step();

        // Single A read with a known device word.
        a_req[0]  = 1'b1;
        a_we[0]   = 1'b0;
        a_addr[0] = 32'h2000_0010;
        eval();
        chk("single_a_gnt", a_gnt[0], 1'b1);
        tick();
        a_req[0]      = 1'b0;
        force_data[0] = 1'b1;
        data_val[0]   = 32'hDEAD_BEEF;
        eval();
        chk("single_a_rvalid", a_rvalid[0], 1'b1);
        chk("single_a_rdata", a_rdata[0], 32'hDEAD_BEEF);
        chk("single_b_rvalid", b_rvalid[0], 1'b0);
        tick();

        // Fixed priority: A wins every contended cycle, B gets in once A lets go.
        for (int i = 0; i < 4; i++) begin
            a_req[2] = 1'b1;
            b_req[2] = 1'b1;
            eval();
            chk("fp_a_gnt", a_gnt[2], 1'b1);
            chk("fp_b_gnt", b_gnt[2], 1'b0);
            tick();
        end
        a_req[2] = 1'b0;
        eval();
        chk("fp_b_gnt_after_a", b_gnt[2], 1'b1);
        tick();
        b_req[2] = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Latency=3: A write then B read, device flags an error only on the B response.
        a_req[2] = 1'b1;
        a_we[2]  = 1'b1;
        step();
        a_req[2] = 1'b0;
        b_req[2] = 1'b1;
        b_we[2]  = 1'b0;
        eval();
        chk("l3_b_gnt", b_gnt[2], 1'b1);
        tick();
        b_req[2] = 1'b0;
        step();
        eval();
        chk("l3_a_rvalid", a_rvalid[2], 1'b1);
        chk("l3_a_err", a_err[2], 1'b0);
        tick();
        eval();
        chk("l3_b_rvalid", b_rvalid[2], 1'b1);
        chk("l3_b_err", b_err[2], 1'b1);
        chk("l3_a_err_quiet", a_err[2], 1'b0);
        tick();

        // Spurious response with nothing outstanding.
        spur[0] = 1'b1;
        eval();
        chk("spur_a_rvalid", a_rvalid[0], 1'b0);
        chk("spur_b_rvalid", b_rvalid[0], 1'b0);
        tick();
        eval();
        chk("spur_perr_set", perr[0], 1'b1);
        tick();
        step();
        eval();
        chk("spur_perr_held", perr[0], 1'b1);
        tick();

        // Missing response on the Latency=2 instance.
        a_req[1] = 1'b1;
        step();
        a_req[1] = 1'b0;
        step();
        drop[1] = 1'b1;
        eval();
        chk("miss_a_rvalid", a_rvalid[1], 1'b0);
        tick();
        eval();
        chk("miss_perr_set", perr[1], 1'b1);
        tick();

        // Reset with two transactions in flight; prio left pointing at B beforehand.
        b_req[1] = 1'b1;
        step();
        b_req[1] = 1'b0;
        a_req[1] = 1'b1;
        step();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        a_req[1] = 1'b1;
        b_req[1] = 1'b1;
        eval();
        chk("post_rst_prio_a", a_gnt[1], 1'b1);
        tick();
        idle_all();
        step();
        step();
        spur[1] = 1'b1;
        step();
        eval();
        chk("late_rsp_perr", perr[1], 1'b1);
        tick();

        // Random traffic across all three configurations.
        do_reset();
        err_on_b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            drive_random();
            step();
        end
        idle_all();
        for (int i = 0; i < 4; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_dev_arbiter.md
# sp_dev_arbiter

Two-requester arbiter that shares one single-port bus device (memory, debug memory, peripheral) between two independent hosts, e.g. core instruction fetch and the system-bus device port. Grants in the request cycle, arbitrates round-robin (or fixed priority) on contention, and routes each response back to the requester that issued it. The shared device's response latency is fixed and known. The arbiter flags any device response that violates that latency.

## Interface
- DataWidth, 32, data bus width
- AddressWidth, 32, address width
- Latency, 1, device cycles from accepted `dev_req_o` to `dev_rvalid_i`; legal 1..4
- FixedPrio, 0, 1 = requester A always wins contention; 0 = round-robin

- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- a_req_i / b_req_i  in  1  request, requester A / B
- a_we_i / b_we_i  in  1  write enable
- a_be_i / b_be_i  in  DataWidth/8  byte enables
- a_addr_i / b_addr_i  in  AddressWidth  address
- a_wdata_i / b_wdata_i  in  DataWidth  write data
- a_gnt_o / b_gnt_o  out  1  request accepted this cycle
- a_rvalid_o / b_rvalid_o  out  1  response valid
- a_rdata_o / b_rdata_o  out  DataWidth  response data
- a_err_o / b_err_o  out  1  response error, qualified by rvalid
- dev_req_o  out  1  device request
- dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o  out  —  muxed from granted requester
- dev_rvalid_i  in  1  device response valid
- dev_rdata_i  in  DataWidth  device read data
- dev_err_i  in  1  device error
- protocol_err_o  out  1  sticky: unexpected or missing device response

## Operation
- Grant is combinational. `dev_req_o = a_req_i | b_req_i`. At most one of a_gnt_o/b_gnt_o is high per cycle, and only when `dev_req_o` is high.
- Single request: that requester is granted.
- Both requesting, FixedPrio=1: A granted.
- Both requesting, FixedPrio=0: the requester named by the `prio` register is granted.
- `prio` update: on any grant to X, `prio` becomes the other requester. With no grant, `prio` holds.
- Device command fields (we/be/addr/wdata) come from the granted requester. When idle they are driven from A.
- Response tracking uses a Latency-deep shift register of {valid, owner}. Each cycle it shifts by one. Entry 0 loads {dev_req_o, granted id}.
- Response routing: when `dev_rvalid_i` is high and the oldest entry is valid, the response goes to the owner's rvalid/err outputs. rdata outputs both carry `dev_rdata_i` unconditionally. The non-owner's rvalid and err are 0.
- Writes also return a response.
- protocol_err_o is set, and stays set until reset, on either condition:
  - `dev_rvalid_i` high while the oldest entry is invalid; the response is dropped and no rvalid is issued.
  - Oldest entry valid but `dev_rvalid_i` low; nothing is issued for that transaction.
- The requester must hold req and command fields stable until granted.

## Timing
- Reset values: prio=A; tracker all invalid; all rvalid_o=0; all err_o=0; protocol_err_o=0.
- gnt_o is combinational from req_i and prio.
- Response for a grant in cycle N appears on the owner's rvalid_o in cycle N+Latency, combinationally from `dev_rvalid_i`.
- Back-to-back grants are allowed every cycle. Throughput is one transfer per cycle.
- Contention: with both requesting continuously and FixedPrio=0, grants strictly alternate A,B,A,B… starting from prio.
- Simultaneous events: a grant and the arrival of a response for an older transaction in the same cycle are independent.
- Reset mid-operation: in-flight tracker entries are discarded and no responses are delivered after reset release. Late device responses arriving after release set protocol_err_o.

## Test plan
- A-only, Latency=1: A read 0x20000010, device returns 0xDEADBEEF next cycle -> a_gnt_o same cycle; a_rvalid_o=1, a_rdata_o=0xDEADBEEF one cycle later; b_rvalid_o=0.
- Continuous A+B contention, FixedPrio=0, 6 cycles -> grants A,B,A,B,A,B; each rvalid routed to the correct owner Latency cycles later.
- FixedPrio=1, both requesting for 4 cycles -> a_gnt_o=1 every cycle, b_gnt_o=0; B granted the first cycle A drops req.
- Latency=3, alternating A write / B read with dev_err_i=1 on the B response -> b_err_o=1 with b_rvalid_o exactly 3 cycles after the B grant; a_err_o=0.
- Spurious response: dev_rvalid_i=1 with no outstanding transaction -> no rvalid_o asserted; protocol_err_o=1 and held until rst_ni low.
- Reset asserted with 2 transactions in flight (Latency=2) -> all outputs zero immediately; no rvalid_o after release; prio=A.
